// File: rtl/fetch_prefetch.sv
// fetch_prefetch: instruction prefetch buffer between CPU fetch/decode and a
// single-port synchronous program memory (1-cycle registered read).
// Sequential reads are issued ahead of decode. Returned words are queued in a
// small FIFO and handed to decode with a valid/ready handshake. The memory port
// is yielded whenever the CPU data path claims it (mem_busy). Flush redirects
// fetch on branches.
//
// Ports:
//   clk        system clock, all state on rising edge
//   rst        synchronous active-high reset (overrides flush)
//   flush      redirect request; discards buffered and in-flight words
//   flush_pc   new fetch word address, valid with flush
//   mem_busy   CPU data path owns the memory port this cycle
//   mem_re     read enable to memory
//   mem_addr   read word address to memory
//   mem_rdata  memory read data, valid the cycle after a read is sampled
//   out_valid  FIFO head holds a word
//   out_ready  decode accepts the head word
//   out_data   head instruction word
//   out_addr   word address of the head word

module fetch_prefetch #(
  parameter int AWIDTH   = 16,
  parameter int DWIDTH   = 16,
  parameter int DEPTH    = 4,
  parameter int RESET_PC = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic [AWIDTH-2:0] flush_pc,
  input  logic              mem_busy,
  output logic              mem_re,
  output logic [AWIDTH-2:0] mem_addr,
  input  logic [DWIDTH-1:0] mem_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DWIDTH-1:0] out_data,
  output logic [AWIDTH-2:0] out_addr
);

  localparam int PW = AWIDTH - 1;       // word address width
  localparam int IW = $clog2(DEPTH);    // FIFO pointer width
  localparam int CW = IW + 1;           // count width, holds 0..DEPTH
  localparam int OW = CW + 1;           // count + in-flight word

  logic [PW-1:0]     fetch_pc_q, fetch_pc_d;
  logic [PW-1:0]     pend_addr_q, pend_addr_d;
  logic              pending_q, pending_d;
  logic [CW-1:0]     count_q, count_d;
  logic [IW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [IW-1:0]     wr_ptr_q, wr_ptr_d;

  logic [DWIDTH-1:0] fifo_data_q [DEPTH];
  logic [PW-1:0]     fifo_addr_q [DEPTH];

  logic              push;
  logic              pop;
  logic [OW-1:0]     occupancy;

  // The in-flight word is counted as occupied, so a capture always finds a
  // free slot and no overflow handling is needed.
  always_comb begin
    occupancy = {1'b0, count_q} + OW'(pending_q);
    mem_re    = !rst && !flush && !mem_busy && (occupancy < OW'(DEPTH));
    mem_addr  = fetch_pc_q;
    out_valid = !rst && (count_q != '0);
    out_data  = fifo_data_q[rd_ptr_q];
    out_addr  = fifo_addr_q[rd_ptr_q];
    // A response is only ours when we issued the read last cycle; otherwise
    // mem_rdata belongs to the CPU data path.
    push      = pending_q && !flush && !rst;
    pop       = out_valid && out_ready && !flush;
  end

  always_comb begin
    fetch_pc_d  = fetch_pc_q;
    pend_addr_d = pend_addr_q;
    pending_d   = 1'b0;
    count_d     = count_q;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    if (flush) begin
      // Drop everything, including the response of a read issued last cycle.
      fetch_pc_d = flush_pc;
      count_d    = '0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
    end else begin
      if (mem_re) begin
        fetch_pc_d  = fetch_pc_q + 1'b1;   // wraps naturally at 2^PW
        pending_d   = 1'b1;
        pend_addr_d = fetch_pc_q;
      end
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q  <= PW'(RESET_PC);
      pend_addr_q <= '0;
      pending_q   <= 1'b0;
      count_q     <= '0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
    end else begin
      fetch_pc_q  <= fetch_pc_d;
      pend_addr_q <= pend_addr_d;
      pending_q   <= pending_d;
      count_q     <= count_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
    end
  end

  // Storage carries no reset; contents are only observed while out_valid=1.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data_q[wr_ptr_q] <= mem_rdata;
      fifo_addr_q[wr_ptr_q] <= pend_addr_q;
    end
  end

  ap_no_overflow: assert property (@(posedge clk) disable iff (rst)
    (push && !pop) |-> (count_q < CW'(DEPTH)));

endmodule
